count_watch: RTL
================

COUNT_WATCH -- requirements
Module: count_watch

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port count_in, input, 4 bits: up/down counter value, sampled every rising edge.
REQ-004 The block SHALL have port m, input, 1 bit: counter direction, 1 = up, 0 = down, sampled with count_in.
REQ-005 The block SHALL have port threshold, input, 4 bits: match value for the alarm FSM.
REQ-006 The block SHALL have port arm, input, 1 bit: level-sampled request to arm the alarm.
REQ-007 The block SHALL have port disarm, input, 1 bit: abort while armed.
REQ-008 The block SHALL have port ack, input, 1 bit: alarm acknowledge.
REQ-009 The block SHALL have port clr, input, 1 bit: synchronous clear of wrap_cnt.
REQ-010 The block SHALL have port wrap_up, output, 1 bit: one-cycle pulse on a 15->0 wrap while m=1.
REQ-011 The block SHALL have port wrap_down, output, 1 bit: one-cycle pulse on a 0->15 wrap while m=0.
REQ-012 The block SHALL have port wrap_cnt, output, 8 bits: saturating count of wrap events.
REQ-013 The block SHALL have port alarm, output, 1 bit: high in ALARM state.
REQ-014 The block SHALL have port armed, output, 1 bit: high in ARMED state.

Function
REQ-015 The block SHALL register count_in into prev_cnt every edge and SHALL set prev_vld to 1 on the first edge after reset release.
REQ-016 The block SHALL NOT detect a wrap while prev_vld=0.
REQ-017 A wrap event SHALL be defined as an up-wrap (prev_vld=1, m=1, prev_cnt=15, count_in=0) or a down-wrap (prev_vld=1, m=0, prev_cnt=0, count_in=15).
REQ-018 For an up-wrap, wrap_up SHALL be high for exactly the cycle following the sampling edge.
REQ-019 For a down-wrap, wrap_down SHALL be high for exactly the cycle following the sampling edge.
REQ-020 A value jump that does not match m (e.g. 15->0 with m=0) SHALL produce no pulse.
REQ-021 wrap_cnt SHALL increment by 1 on each wrap event, registered, with the same timing as the pulses.
REQ-022 wrap_cnt SHALL saturate at 255.
REQ-023 clr SHALL set wrap_cnt to 0 and SHALL take priority over a simultaneous wrap event.
REQ-024 The FSM SHALL have four states: IDLE, ARMED, ALARM, HOLD.
REQ-025 FSM transitions SHALL be evaluated on each rising edge, priority top to bottom:
  - IDLE: arm=1 -> ARMED.
  - ARMED: disarm=1 -> IDLE; else count_in==threshold -> ALARM.
  - ALARM: ack=1 and count_in==threshold -> HOLD; ack=1 -> IDLE; arm is ignored.
  - HOLD: count_in!=threshold -> IDLE; arm and disarm are ignored.
REQ-026 alarm SHALL be asserted only in ALARM, starting the cycle after the matching edge.
REQ-027 armed SHALL be asserted only in ARMED.
REQ-028 A threshold change while ARMED SHALL take effect on the next edge.
REQ-029 arm=1 coincident with a threshold match in IDLE SHALL only enter ARMED; the match SHALL be checked on the next edge.

Reset
REQ-030 Reset assertion SHALL immediately force: FSM=IDLE, prev_cnt=0, prev_vld=0, wrap_up=0, wrap_down=0, wrap_cnt=0, alarm=0, armed=0.
REQ-031 Reset asserted mid-ALARM or mid-HOLD SHALL abandon the alarm; no ack SHALL be required afterwards.

Configuration
REQ-032 With COUNT_WATCH_WRAP_CNT_EN defined, the wrap_cnt counter SHALL be implemented per REQ-021..REQ-023.
REQ-033 Without COUNT_WATCH_WRAP_CNT_EN, wrap_cnt SHALL be constant 0, clr SHALL be ignored, and the wrap_up/wrap_down pulses SHALL remain unchanged.

Verification
REQ-034 Up wrap: m=1, count 14,15,0,1 -> wrap_up high one cycle after the 0 sample; wrap_cnt 0->1; wrap_down stays 0.
REQ-035 Down wrap, then bad jump: m=0, count 1,0,15 -> wrap_down pulse and wrap_cnt=1; then m=0, count 15->0 -> no pulse.
REQ-036 Alarm path: threshold=9, arm pulse, up-count from 0 -> armed high, then alarm high the cycle after the 9 sample; ack while count=9 -> HOLD; count=10 -> IDLE.
REQ-037 Saturation and clear: 300 up wraps -> wrap_cnt=255; clr coincident with a wrap -> wrap_cnt=0.
REQ-038 Reset mid-operation: assert reset in ALARM with wrap_cnt=5 -> all outputs 0 asynchronously; the first sample after release, even 15->0, gives no wrap pulse.
REQ-039 Macro off: build without COUNT_WATCH_WRAP_CNT_EN, repeat REQ-034 -> wrap_up pulse present, wrap_cnt=0 throughout.

Source files
------------

// File: rtl/count_watch.sv
// Up/down counter wrap watcher with a threshold alarm FSM.
// Optional wrap-event counter enabled by defining COUNT_WATCH_WRAP_CNT_EN.
module count_watch (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] count_in,
   input  logic       m,
   input  logic [3:0] threshold,
   input  logic       arm,
   input  logic       disarm,
   input  logic       ack,
   input  logic       clr,
   output logic       wrap_up,
   output logic       wrap_down,
   output logic [7:0] wrap_cnt,
   output logic       alarm,
   output logic       armed
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ALARM, S_HOLD} state_t;

   state_t     state, state_nxt;
   logic [3:0] prev_cnt;
   logic       prev_vld;
   logic       up_ev, dn_ev, match;

   // The first sample after reset has no valid predecessor, so it never counts as a wrap.
   assign up_ev = prev_vld &  m & (prev_cnt == 4'd15) & (count_in == 4'd0);
   assign dn_ev = prev_vld & ~m & (prev_cnt == 4'd0)  & (count_in == 4'd15);
   assign match = (count_in == threshold);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_cnt  <= 4'd0;
         prev_vld  <= 1'b0;
         wrap_up   <= 1'b0;
         wrap_down <= 1'b0;
      end else begin
         prev_cnt  <= count_in;
         prev_vld  <= 1'b1;
         wrap_up   <= up_ev;
         wrap_down <= dn_ev;
      end
   end

`ifdef COUNT_WATCH_WRAP_CNT_EN
   // clr wins over a coincident wrap; counter holds at 255.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wrap_cnt <= 8'd0;
      else if (clr)
         wrap_cnt <= 8'd0;
      else if ((up_ev | dn_ev) && (wrap_cnt != 8'hFF))
         wrap_cnt <= wrap_cnt + 8'd1;
   end
`else
   logic clr_unused;
   assign clr_unused = clr;
   assign wrap_cnt   = 8'd0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (arm) state_nxt = S_ARMED;
         S_ARMED: begin
            if (disarm)     state_nxt = S_IDLE;
            else if (match) state_nxt = S_ALARM;
         end
         S_ALARM: begin
            if (ack && match) state_nxt = S_HOLD;
            else if (ack)     state_nxt = S_IDLE;
         end
         S_HOLD:  if (!match) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign alarm = (state == S_ALARM);
   assign armed = (state == S_ARMED);

endmodule
